// File: rtl/dinl_pkg.sv
// Shared types and constants for the DINL table loader.
package dinl_pkg;

  localparam int DINL_NLANES     = 32;
  localparam int DINL_CHAIN_LEN  = 64;
  localparam int DINL_COUNT_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } dinl_state_e;

  function automatic logic [DINL_NLANES-1:0] dinl_apply_mask(
    input logic [DINL_NLANES-1:0] plane,
    input logic [DINL_NLANES-1:0] mask
  );
    return plane & mask;
  endfunction

endpackage

// File: rtl/dinl_plane_ram.sv
// Bit-plane table RAM: one write port, one loader read port, and an extra
// independent read port when DINL_READBACK_EN is defined. Not reset.
module dinl_plane_ram #(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]     i_wr_dat,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [WIDTH-1:0]     o_rd_dat
`ifdef DINL_READBACK_EN
  ,
  input  logic [ADDR_BITS-1:0] i_rb_addr,
  output logic [WIDTH-1:0]     o_rb_dat
`endif
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_dat;

`ifdef DINL_READBACK_EN
  logic [WIDTH-1:0] r_rb_dat;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
    r_rd_dat <= r_mem[i_rd_addr];
    r_rb_dat <= r_mem[i_rb_addr];
  end

  assign o_rb_dat = r_rb_dat;
`else
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
    r_rd_dat <= r_mem[i_rd_addr];
  end
`endif

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/dinl_table_loader.sv
// Streams staged INL bit-planes MSB-first onto the DINL serial bus.
// Define DINL_READBACK_EN to add the rd_addr_i / rd_dat_o readback port.
module dinl_table_loader
  import dinl_pkg::*;
#(
  parameter int CHAIN_LEN = DINL_CHAIN_LEN,
  parameter int NLANES    = DINL_NLANES,
  parameter int ADDR_BITS = $clog2(CHAIN_LEN)
) (
  input  logic                       sysclk_i,
  input  logic                       rst_i,
  input  logic                       wr_i,
  input  logic [ADDR_BITS-1:0]       wr_addr_i,
  input  logic [NLANES-1:0]          wr_dat_i,
  input  logic [NLANES-1:0]          lane_mask_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  output logic [NLANES-1:0]          dinl_cdi_o,
  output logic                       dinl_ce_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       wr_err_o,
  output logic [DINL_COUNT_BITS-1:0] load_count_o
`ifdef DINL_READBACK_EN
  ,
  input  logic [ADDR_BITS-1:0]       rd_addr_i,
  output logic [NLANES-1:0]          rd_dat_o
`endif
);

  dinl_state_e                r_state, w_state_next;
  logic [ADDR_BITS-1:0]       r_ptr, w_ptr_next, w_rd_addr;
  logic                       r_last, w_last_next;
  logic [NLANES-1:0]          r_mask, w_mask_next;
  logic [NLANES-1:0]          r_cdi, w_cdi_next, w_plane;
  logic                       r_ce, w_ce_next;
  logic                       r_busy, w_busy_next;
  logic                       r_done, w_done_next;
  logic                       r_wr_err, w_wr_err_next;
  logic [DINL_COUNT_BITS-1:0] r_count, w_count_next;
  logic                       w_wr_en;

  dinl_plane_ram #(
    .DEPTH     (CHAIN_LEN),
    .WIDTH     (NLANES),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clk     (sysclk_i),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wr_addr_i),
    .i_wr_dat  (wr_dat_i),
    .i_rd_addr (w_rd_addr),
    .o_rd_dat  (w_plane)
`ifdef DINL_READBACK_EN
    ,
    .i_rb_addr (rd_addr_i),
    .o_rb_dat  (rd_dat_o)
`endif
  );

  // r_ptr is the plane currently held at the RAM output; the address always
  // runs one plane ahead so the serial stream never stalls.
  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_last_next   = r_last;
    w_mask_next   = r_mask;
    w_rd_addr     = r_ptr - ADDR_BITS'(1);
    w_wr_en       = 1'b0;
    w_wr_err_next = r_wr_err;
    w_ce_next     = 1'b0;
    w_cdi_next    = '0;
    w_done_next   = 1'b0;
    w_count_next  = r_count;

    case (r_state)
      ST_IDLE: begin
        w_wr_en = wr_i;
        if (start_i) begin
          w_state_next  = ST_PREP;
          w_mask_next   = lane_mask_i;
          w_wr_err_next = 1'b0;
          w_ptr_next    = ADDR_BITS'(CHAIN_LEN - 1);
          w_rd_addr     = ADDR_BITS'(CHAIN_LEN - 1);
          w_last_next   = 1'b0;
        end
      end
      ST_PREP, ST_SHIFT: begin
        if (abort_i) begin
          w_state_next = ST_IDLE;
        end else if (r_state == ST_SHIFT && r_last) begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
          w_count_next = r_count + DINL_COUNT_BITS'(1);
        end else begin
          w_state_next = ST_SHIFT;
          w_ce_next    = 1'b1;
          w_cdi_next   = dinl_apply_mask(w_plane, r_mask);
          w_ptr_next   = r_ptr - ADDR_BITS'(1);
          w_last_next  = (r_ptr == '0);
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (r_state != ST_IDLE && wr_i) w_wr_err_next = 1'b1;
    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_last   <= 1'b0;
      r_mask   <= '1;
      r_cdi    <= '0;
      r_ce     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_last   <= w_last_next;
      r_mask   <= w_mask_next;
      r_cdi    <= w_cdi_next;
      r_ce     <= w_ce_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_wr_err <= w_wr_err_next;
      r_count  <= w_count_next;
    end
  end

  assign dinl_cdi_o   = r_cdi;
  assign dinl_ce_o    = r_ce;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign wr_err_o     = r_wr_err;
  assign load_count_o = r_count;

endmodule

// File: tb/tb_dinl_table_loader.sv
// Self-checking bench for dinl_table_loader against a cycle-timeline model.
module tb_dinl_table_loader;
  import dinl_pkg::*;

  localparam int CL = DINL_CHAIN_LEN;
  localparam int AW = $clog2(CL);

  logic          sysclk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_dat = '0;
  logic [31:0]   lane_mask = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   cdi;
  logic          ce, busy, done, wr_err;
  logic [7:0]    count;
`ifdef DINL_READBACK_EN
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_dat;
`endif

  always #5 sysclk = ~sysclk;

  dinl_table_loader dut (
    .sysclk_i     (sysclk),
    .rst_i        (rst),
    .wr_i         (wr),
    .wr_addr_i    (wr_addr),
    .wr_dat_i     (wr_dat),
    .lane_mask_i  (lane_mask),
    .start_i      (start),
    .abort_i      (abort),
    .dinl_cdi_o   (cdi),
    .dinl_ce_o    (ce),
    .busy_o       (busy),
    .done_o       (done),
    .wr_err_o     (wr_err),
    .load_count_o (count)
`ifdef DINL_READBACK_EN
    ,
    .rd_addr_i    (rd_addr),
    .rd_dat_o     (rd_dat)
`endif
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] m_ram [CL];
  logic [31:0] m_mask;
  logic [7:0]  m_count;
  logic        m_err;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] fill;
    logic [31:0] exp_cdi;
  } vec_t;
  vec_t tbl [6];

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic [43:0] act_vec();
    return {busy, ce, done, wr_err, count, cdi};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_plane(input int a, input logic [31:0] d);
    wr = 1'b1; wr_addr = AW'(a); wr_dat = d;
    tick();
    wr = 1'b0;
    m_ram[a] = d;
  endtask

`ifdef DINL_READBACK_EN
  task automatic rb_chk(input int a);
    rd_addr = AW'(a);
    tick();
    chk($sformatf("readback %0d", a), 64'(rd_dat), 64'(m_ram[a]));
  endtask
`endif

  // k counts cycles after the one in which start is driven.
  task automatic run_load(input logic [31:0] mask, input int abort_k, input int wr_k,
                          input int xstart_k, input string tag, output logic [31:0] first_cdi);
    bit aborted;
    logic eb, ece, edn;
    logic [31:0] ecdi;
    aborted   = (abort_k >= 1 && abort_k <= CL + 1);
    first_cdi = '0;
    lane_mask = mask; start = 1'b1; abort = (abort_k == 0);
    tick();
    start = 1'b0; abort = 1'b0; lane_mask = $urandom();
    m_mask = mask; m_err = 1'b0;
    for (int k = 1; k <= CL + 3; k++) begin
      if (aborted && k > abort_k) begin
        eb = 1'b0; ece = 1'b0; edn = 1'b0;
      end else begin
        eb = (k <= CL + 2); ece = (k >= 2 && k <= CL + 1); edn = (k == CL + 2);
      end
      if (edn) m_count++;
      ecdi = ece ? (m_ram[CL + 1 - k] & m_mask) : 32'h0;
      if (k == 2) first_cdi = cdi;
      chk($sformatf("%s k=%0d", tag, k), 64'(act_vec()),
          64'({eb, ece, edn, m_err, m_count, ecdi}));
      if ((aborted && k > abort_k) || k == CL + 3) break;
      abort = (k == abort_k);
      start = (k == xstart_k);
      if (k == wr_k) begin
        wr = 1'b1; wr_addr = AW'(5); wr_dat = $urandom();
      end
      tick();
      abort = 1'b0; start = 1'b0; wr = 1'b0;
      if (k == wr_k && eb) m_err = 1'b1;
    end
    $display("[TB] load %s mask=%h count=%0d", tag, mask, m_count);
  endtask

  initial begin
    logic [31:0] fc;
    logic [7:0]  a8;
    m_count = '0; m_err = 1'b0; m_mask = '1;

    rst = 1'b1;
    tick();
    chk("reset state", 64'(act_vec()), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("idle after reset", 64'(act_vec()), 64'(0));

    for (int a = 0; a < CL; a++) begin
      a8 = 8'(a);
      write_plane(a, {a8, ~a8, a8, ~a8});
    end
    run_load(32'hFFFF_FFFF, -1, -1, -1, "ramp", fc);
    chk("ramp first plane", 64'(fc), 64'(32'h3FC0_3FC0));
    chk("ramp count", 64'(count), 64'(1));

    tbl[0] = '{mask: 32'h0000_FFFF, fill: 32'hFFFF_FFFF, exp_cdi: 32'h0000_FFFF};
    tbl[1] = '{mask: 32'hFFFF_FFFF, fill: 32'hA5A5_A5A5, exp_cdi: 32'hA5A5_A5A5};
    tbl[2] = '{mask: 32'h0000_0000, fill: 32'hFFFF_FFFF, exp_cdi: 32'h0000_0000};
    tbl[3] = '{mask: 32'hF0F0_F0F0, fill: 32'h3C3C_3C3C, exp_cdi: 32'h3030_3030};
    tbl[4] = '{mask: 32'h8000_0001, fill: 32'h7FFF_FFFE, exp_cdi: 32'h0000_0000};
    tbl[5] = '{mask: 32'h8000_0001, fill: 32'hFFFF_FFFF, exp_cdi: 32'h8000_0001};
    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < CL; a++) write_plane(a, tbl[i].fill);
      run_load(tbl[i].mask, -1, -1, -1, $sformatf("tbl%0d", i), fc);
      chk($sformatf("tbl%0d cdi", i), 64'(fc), 64'(tbl[i].exp_cdi));
    end

    for (int a = 0; a < CL; a++) write_plane(a, $urandom());
    run_load(32'hFFFF_FFFF, 21, -1, -1, "abort shift20", fc);
    run_load(32'hFFFF_FFFF, -1, -1, -1, "after abort", fc);
    run_load(32'hFFFF_FFFF, 1, -1, -1, "abort prep", fc);
    run_load(32'hFFFF_FFFF, 0, -1, -1, "abort with start", fc);
    run_load(32'hFFFF_FFFF, CL + 2, -1, -1, "abort in done", fc);

    run_load(32'hFFFF_FFFF, -1, 30, -1, "write busy", fc);
`ifdef DINL_READBACK_EN
    rb_chk(5);
    rb_chk(CL - 1);
`endif
    run_load(32'hFFFF_FFFF, -1, -1, -1, "err cleared", fc);

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < CL; a++) write_plane(a, $urandom());
      run_load($urandom(), -1, -1, int'($urandom_range(1, CL + 2)), $sformatf("rand%0d", r), fc);
    end

    lane_mask = '1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    #2 rst = 1'b1;
    #1 chk("async reset mid shift", 64'(act_vec()), 64'(0));
    m_count = '0; m_err = 1'b0; m_mask = '1;
    tick();
    rst = 1'b0;
    tick();
    chk("idle after mid reset", 64'(act_vec()), 64'(0));
    $display("[TB] reset mid-shift applied");

    for (int i = 0; i < 256; i++)
      run_load(32'hFFFF_FFFF, -1, -1, 10 + (i % 50), $sformatf("b2b%0d", i), fc);
    chk("count wrap", 64'(count), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dinl_table_loader.md
# dinl_table_loader

Sequencer that loads the dynamic INL code-remap tables into all 32 quad correlators (16 per RITC) of the dual-RITC correlator. Software stages one bit-plane per address in a local table RAM. On command, the block streams the planes MSB-first onto the shared serial configuration bus (`dinl_cdi_o` one bit per quad, `dinl_ce_o` common) at sysclk rate. It sits between the register interface and the correlator array and is the only driver of the DINL bus.

## Interface
Parameters:
- `CHAIN_LEN`, 64: bits per quad remap chain = number of bit-planes; power of two, 8..256.
- `NLANES`, 32: quad correlators (bits of cdi); fixed 32 in this design.
- `ADDR_BITS`, $clog2(CHAIN_LEN): plane address width.

Ports:
- `sysclk_i`  in  1  system clock; sole clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `wr_i`  in  1  plane write strobe.
- `wr_addr_i`  in  ADDR_BITS  plane index.
- `wr_dat_i`  in  NLANES  plane data, bit n -> quad n.
- `lane_mask_i`  in  NLANES  1 = lane participates; sampled at start.
- `start_i`  in  1  single-cycle load command.
- `abort_i`  in  1  single-cycle abort.
- `dinl_cdi_o`  out  NLANES  serial data to quads.
- `dinl_ce_o`  out  1  shift enable to quads.
- `busy_o`  out  1  load in progress.
- `done_o`  out  1  one-cycle pulse on successful completion.
- `wr_err_o`  out  1  sticky; write attempted while busy. Cleared by a start that is accepted.
- `load_count_o`  out  8  completed loads, wraps 255 -> 0.
- `rd_addr_i`  in  ADDR_BITS  readback address (only with `DINL_READBACK_EN`).
- `rd_dat_o`  out  NLANES  readback data (only with `DINL_READBACK_EN`).

## Operation
- States: IDLE, PREP, SHIFT, DONE.
- IDLE:
  - `wr_i` writes the RAM.
  - `start_i` latches `lane_mask_i`, clears `wr_err_o`, sets the plane pointer to CHAIN_LEN-1, and moves to PREP.
- PREP: one cycle for the RAM read of plane CHAIN_LEN-1; then SHIFT.
- SHIFT:
  - Each cycle, `dinl_ce_o` = 1 and `dinl_cdi_o` = plane[ptr] & mask. Masked lanes drive 0.
  - The pointer decrements. The next plane is prefetched so that output is continuous.
  - After the plane 0 cycle (CHAIN_LEN cycles total), go to DONE.
- DONE: `done_o` = 1 and `load_count_o` increments, both for one cycle; then IDLE.
- `busy_o` = 1 in PREP, SHIFT and DONE.
- `wr_i` while busy: the write is dropped (RAM unchanged) and `wr_err_o` is set.
- `start_i` while busy is ignored.
- `abort_i` in any non-IDLE state:
  - Next cycle the state is IDLE, with `dinl_ce_o` = 0 and `dinl_cdi_o` = 0.
  - No `done_o` pulse and no count increment.
  - Quad tables are partially shifted; software must reload.
- `abort_i` and `start_i` in the same IDLE cycle: start is taken and abort is ignored.
- `abort_i` in the DONE cycle: done still completes.
- When `dinl_ce_o` = 0, `dinl_cdi_o` = 0.

## Timing
- Reset values: `dinl_cdi_o` = 0, `dinl_ce_o` = 0, `busy_o` = 0, `done_o` = 0, `wr_err_o` = 0, `load_count_o` = 0, state IDLE, mask all-ones.
- The RAM is not reset.
- All outputs are registered.
- `start_i` at edge t:
  - `busy_o` = 1 from t+1.
  - `dinl_ce_o` = 1 from t+2 through t+CHAIN_LEN+1.
  - `done_o` pulses at t+CHAIN_LEN+2.
  - `busy_o` falls at t+CHAIN_LEN+3.
- Total occupancy is CHAIN_LEN+2 cycles; a start is accepted again at t+CHAIN_LEN+3.
- Write at edge t: the data is visible to a load started at t+1 or later.
- Readback latency: 1 cycle, valid in all states.
- Reset asserted mid-SHIFT: outputs go to reset values immediately (asynchronous); `load_count_o` clears.

## Configuration
- `DINL_READBACK_EN` defined:
  - `rd_addr_i` and `rd_dat_o` are present.
  - The RAM is dual-port, with the read port independent of the loader.
- Not defined:
  - The ports are absent.
  - The RAM is single-port, with the loader as sole reader.
  - Load behaviour is identical.

## Structure
- Package `dinl_pkg`:
  - state enum.
  - `DINL_NLANES` = 32.
  - default `DINL_CHAIN_LEN` = 64.
  - `DINL_COUNT_BITS` = 8.
- Sub-module `dinl_plane_ram`:
  - CHAIN_LEN × NLANES, synchronous write and synchronous read.
  - Second read port under `DINL_READBACK_EN`.
- The FSM, pointer, mask register and counter live in the top.

## Test plan
- Write planes 0..63 with data = {addr, ~addr, addr, ~addr} (8-bit fields); start at cycle 10 -> `dinl_ce_o` high cycles 12..75; cdi at cycle 12 = plane 63, at cycle 75 = plane 0; `done_o` at 76; `load_count_o` = 1.
- Mask = 0x0000FFFF, all planes 0xFFFFFFFF -> cdi = 0x0000FFFF on every ce cycle.
- Abort on the 20th SHIFT cycle -> ce and cdi are 0 next cycle; no done; count unchanged; a new start completes normally.
- Write during SHIFT to plane 5 -> `wr_err_o` = 1; RAM plane 5 unchanged (readback); the next accepted start clears `wr_err_o`.
- 256 back-to-back loads (start asserted one cycle after each busy falls) -> `load_count_o` wraps to 0; start pulses while busy are ignored.
- Reset asserted mid-SHIFT -> all outputs at reset values before the next edge; the count clears.
